// File: rtl/muldiv_ctrl.sv
// muldiv_ctrl: bit-serial multiply/divide sequencer that owns the HI/LO pair.
//
// Runs MULT, MULTU, DIV and DIVU one bit per clock. Signed operations work on
// operand magnitudes, and a single FIX cycle restores the signs. Results commit
// to o_hi/o_lo on entry to DONE. Between results o_hi/o_lo hold their values.
//
// Optional build macro: MULDIV_EARLY_OUT_EN
//   When defined, a multiply leaves RUN as soon as the remaining multiplier
//   bits are all zero. Divide always runs WIDTH iterations.
//
// Ports:
//   i_clk        clock, rising edge
//   i_rst_n      asynchronous active-low reset
//   i_start      start request (accepted in IDLE only)
//   i_op         00 MULT, 01 MULTU, 10 DIV, 11 DIVU
//   i_srcLeft    multiplicand / dividend
//   i_srcRight   multiplier / divisor
//   i_readHiLo   a younger instruction wants HI/LO this cycle
//   i_flush      cancel an operation in RUN or FIX
//   o_busy       unit is not IDLE
//   o_stallReq   stall request: busy and (start or HI/LO read)
//   o_done       one-cycle pulse in the cycle o_hi/o_lo show a new result
//   o_hi, o_lo   result registers
module muldiv_ctrl #(
  parameter int WIDTH = 32
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_start,
  input  logic [1:0]       i_op,
  input  logic [WIDTH-1:0] i_srcLeft,
  input  logic [WIDTH-1:0] i_srcRight,
  input  logic             i_readHiLo,
  input  logic             i_flush,
  output logic             o_busy,
  output logic             o_stallReq,
  output logic             o_done,
  output logic [WIDTH-1:0] o_hi,
  output logic [WIDTH-1:0] o_lo
);

  localparam int CNT_W = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {IDLE, RUN, FIX, DONE} state_t;

  state_t state, state_next;

  logic               op_div;
  logic               sign_q;
  logic               sign_r;
  logic               div_zero;
  logic [CNT_W-1:0]   cnt;
  logic [2*WIDTH-1:0] acc;
  logic [2*WIDTH-1:0] mcand;
  logic [WIDTH-1:0]   mplier;
  logic [WIDTH-1:0]   rem;
  logic [WIDTH-1:0]   dvd;
  logic [WIDTH-1:0]   divisor;
  logic [WIDTH-1:0]   left_raw;

  logic               is_signed_op;
  logic [WIDTH-1:0]   left_mag;
  logic [WIDTH-1:0]   right_mag;
  logic [WIDTH-1:0]   mplier_shift;
  logic [WIDTH:0]     rem_shift;
  logic [WIDTH-1:0]   rem_diff;
  logic [WIDTH-1:0]   rem_next;
  logic               q_bit;
  logic               last_iter;
  logic [2*WIDTH-1:0] prod;
  logic [WIDTH-1:0]   hi_result;
  logic [WIDTH-1:0]   lo_result;

  // Two's-complement magnitude; the most negative value maps onto itself,
  // which is its correct unsigned magnitude.
  function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] v,
                                                 input logic is_signed);
    logic signed [WIDTH-1:0] sv;
    sv = v;
    return (is_signed && sv[WIDTH-1]) ? -sv : sv;
  endfunction

  function automatic logic [WIDTH-1:0] neg_w(input logic [WIDTH-1:0] v,
                                             input logic neg);
    return neg ? -v : v;
  endfunction

  function automatic logic [2*WIDTH-1:0] neg_2w(input logic [2*WIDTH-1:0] v,
                                                input logic neg);
    return neg ? -v : v;
  endfunction

  assign is_signed_op = ~i_op[0];
  assign left_mag     = magnitude(i_srcLeft, is_signed_op);
  assign right_mag    = magnitude(i_srcRight, is_signed_op);

  // Restoring divide step. The shifted remainder keeps one extra bit so that
  // divisors with the top bit set still compare correctly.
  assign rem_shift    = {rem, dvd[WIDTH-1]};
  assign q_bit        = (rem_shift >= {1'b0, divisor});
  assign rem_diff     = rem_shift[WIDTH-1:0] - divisor;
  assign rem_next     = q_bit ? rem_diff : rem_shift[WIDTH-1:0];
  assign mplier_shift = mplier >> 1;

`ifdef MULDIV_EARLY_OUT_EN
  assign last_iter = (cnt == CNT_W'(WIDTH - 1)) || (!op_div && (mplier_shift == '0));
`else
  assign last_iter = (cnt == CNT_W'(WIDTH - 1));
`endif

  // Sign correction and result selection, consumed on the FIX -> DONE edge
  always_comb begin
    prod = neg_2w(acc, sign_q);
    if (op_div) begin
      if (div_zero) begin
        hi_result = left_raw;
        lo_result = '1;
      end else begin
        hi_result = neg_w(rem, sign_r);
        lo_result = neg_w(dvd, sign_q);
      end
    end else begin
      hi_result = prod[2*WIDTH-1:WIDTH];
      lo_result = prod[WIDTH-1:0];
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) state <= IDLE;
    else          state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (i_start && !i_flush) state_next = RUN;
      RUN:     if (i_flush) state_next = IDLE;
               else if (last_iter) state_next = FIX;
      FIX:     state_next = i_flush ? IDLE : DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    o_busy     = (state != IDLE);
    o_done     = (state == DONE);
    o_stallReq = o_busy & (i_start | i_readHiLo);
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      op_div   <= 1'b0;
      sign_q   <= 1'b0;
      sign_r   <= 1'b0;
      div_zero <= 1'b0;
      cnt      <= '0;
      acc      <= '0;
      mcand    <= '0;
      mplier   <= '0;
      rem      <= '0;
      dvd      <= '0;
      divisor  <= '0;
      left_raw <= '0;
      o_hi     <= '0;
      o_lo     <= '0;
    end else begin
      case (state)
        // Operand capture
        IDLE: begin
          if (i_start && !i_flush) begin
            op_div   <= i_op[1];
            sign_q   <= is_signed_op & (i_srcLeft[WIDTH-1] ^ i_srcRight[WIDTH-1]);
            sign_r   <= is_signed_op & i_srcLeft[WIDTH-1];
            div_zero <= i_op[1] & (i_srcRight == '0);
            cnt      <= '0;
            acc      <= '0;
            mcand    <= {{WIDTH{1'b0}}, left_mag};
            mplier   <= right_mag;
            rem      <= '0;
            dvd      <= left_mag;
            divisor  <= right_mag;
            left_raw <= i_srcLeft;
          end
        end
        // One iteration per cycle
        RUN: begin
          if (!i_flush) begin
            cnt <= cnt + CNT_W'(1);
            if (op_div) begin
              rem <= rem_next;
              dvd <= {dvd[WIDTH-2:0], q_bit};
            end else begin
              if (mplier[0]) acc <= acc + mcand;
              mcand  <= mcand << 1;
              mplier <= mplier_shift;
            end
          end
        end
        // Commit; new values are visible during DONE
        FIX: begin
          if (!i_flush) begin
            o_hi <= hi_result;
            o_lo <= lo_result;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
